// File: rtl/ecp5pll_phase_pkg.sv
// rtl/ecp5pll_phase_pkg.sv - shared types and constants for the ECP5 PLL phase sequencer
// Holds the sequencer state encoding, default timing lengths and the
// phasedir encoding used on the ECP5 PLL dynamic phase-shift pins.
package ecp5pll_phase_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      PULSE  = 3'd2,
      SETTLE = 3'd3,
      LOAD   = 3'd4,
      DONE   = 3'd5
   } state_t;

   localparam int DEF_PHASE_BITS    = 8;
   localparam int DEF_PHASE_INIT    = 0;
   localparam int DEF_SETUP_CYCLES  = 4;
   localparam int DEF_PULSE_CYCLES  = 4;
   localparam int DEF_SETTLE_CYCLES = 16;

   // Width of the shared state timer; must hold the longest (length-1).
   localparam int TIMER_BITS = 16;

   localparam logic DIR_INC = 1'b0;
   localparam logic DIR_DEC = 1'b1;

endpackage

// File: rtl/ecp5pll_phase_seq.sv
// rtl/ecp5pll_phase_seq.sv - moves the ECP5 PLL output phase to a requested absolute value
// Optional feature macro: ECP5PLL_PHASE_SEQ_ABORT_EN (adds the abort input).
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   target, target_valid      requested absolute phase, valid/ready handshake
//   abort                     (macro only) stop after the current step, then load
//   target_ready              high only while idle
//   phase                     currently tracked phase
//   busy, done                not idle / one-cycle completion pulse
//   phasedir, phasestep,      ECP5 PLL dynamic phase-shift controls
//   phaseloadreg
module ecp5pll_phase_seq
   import ecp5pll_phase_pkg::*;
#(
   parameter int C_phase_bits    = DEF_PHASE_BITS,
   parameter int C_phase_init    = DEF_PHASE_INIT,
   parameter int C_setup_cycles  = DEF_SETUP_CYCLES,
   parameter int C_pulse_cycles  = DEF_PULSE_CYCLES,
   parameter int C_settle_cycles = DEF_SETTLE_CYCLES
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [C_phase_bits-1:0] target,
   input  logic                    target_valid,
`ifdef ECP5PLL_PHASE_SEQ_ABORT_EN
   input  logic                    abort,
`endif
   output logic                    target_ready,
   output logic [C_phase_bits-1:0] phase,
   output logic                    busy,
   output logic                    done,
   output logic                    phasedir,
   output logic                    phasestep,
   output logic                    phaseloadreg
);

   localparam logic [C_phase_bits-1:0] PH_ONE  = C_phase_bits'(1);
   localparam logic [TIMER_BITS-1:0]   T_SETUP  = TIMER_BITS'(C_setup_cycles - 1);
   localparam logic [TIMER_BITS-1:0]   T_PULSE  = TIMER_BITS'(C_pulse_cycles - 1);
   localparam logic [TIMER_BITS-1:0]   T_SETTLE = TIMER_BITS'(C_settle_cycles - 1);

   state_t                  state_q, state_d;
   logic [TIMER_BITS-1:0]   timer_q, timer_d;
   logic [C_phase_bits-1:0] remain_q, remain_d;
   logic [C_phase_bits-1:0] phase_q, phase_d;
   logic                    dir_q, dir_d;
   logic                    abort_pend_q, abort_pend_d;
   logic                    ready_q, ready_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    step_q, step_d;
   logic                    load_q, load_d;

   logic [C_phase_bits-1:0] diff;
   logic                    timer_end;
   logic                    abort_in;

`ifdef ECP5PLL_PHASE_SEQ_ABORT_EN
   assign abort_in = abort;
`else
   assign abort_in = 1'b0;
`endif

   // Modulo difference; its MSB picks the shorter direction (half-turn goes down).
   assign diff      = target - phase_q;
   assign timer_end = (timer_q == '0);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         timer_q      <= '0;
         remain_q     <= '0;
         phase_q      <= C_phase_bits'(C_phase_init);
         dir_q        <= DIR_INC;
         abort_pend_q <= 1'b0;
         ready_q      <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         step_q       <= 1'b1;
         load_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         remain_q     <= remain_d;
         phase_q      <= phase_d;
         dir_q        <= dir_d;
         abort_pend_q <= abort_pend_d;
         ready_q      <= ready_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         step_q       <= step_d;
         load_q       <= load_d;
      end
   end

   // Next-state logic; the timer is reloaded with (length-1) on every state entry.
   always_comb begin
      state_d      = state_q;
      timer_d      = timer_end ? timer_q : timer_q - TIMER_BITS'(1);
      remain_d     = remain_q;
      phase_d      = phase_q;
      dir_d        = dir_q;
      abort_pend_d = abort_pend_q;
      case (state_q)
         IDLE: begin
            abort_pend_d = 1'b0;
            if (target_valid) begin
               dir_d    = diff[C_phase_bits-1] ? DIR_DEC : DIR_INC;
               remain_d = diff[C_phase_bits-1] ? ('0 - diff) : diff;
               if (diff == '0) begin
                  state_d = DONE;
                  timer_d = '0;
               end else begin
                  state_d = SETUP;
                  timer_d = T_SETUP;
               end
            end
         end
         SETUP: begin
            if (abort_in) begin
               state_d = LOAD;
               timer_d = T_PULSE;
            end else if (timer_end) begin
               state_d = PULSE;
               timer_d = T_PULSE;
            end
         end
         PULSE: begin
            if (abort_in) abort_pend_d = 1'b1;
            if (timer_end) begin
               state_d  = SETTLE;
               timer_d  = T_SETTLE;
               phase_d  = (dir_q == DIR_DEC) ? phase_q - PH_ONE : phase_q + PH_ONE;
               remain_d = remain_q - PH_ONE;
            end
         end
         SETTLE: begin
            if (abort_in) abort_pend_d = 1'b1;
            if (timer_end) begin
               if (remain_q == '0 || abort_pend_q || abort_in) begin
                  state_d = LOAD;
                  timer_d = T_PULSE;
               end else begin
                  state_d = SETUP;
                  timer_d = T_SETUP;
               end
            end
         end
         LOAD: begin
            if (timer_end) begin
               state_d = DONE;
               timer_d = '0;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs decoded from the next state so that they are registered yet
   // aligned with the state they belong to.
   always_comb begin
      ready_d = (state_d == IDLE);
      busy_d  = (state_d != IDLE);
      done_d  = (state_d == DONE);
      step_d  = (state_d != PULSE);
      load_d  = (state_d == LOAD);
   end

   assign target_ready = ready_q;
   assign phase        = phase_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign phasedir     = dir_q;
   assign phasestep    = step_q;
   assign phaseloadreg = load_q;

endmodule

// File: tb/tb_ecp5pll_phase_seq.sv
// tb/tb_ecp5pll_phase_seq.sv - table-driven self-checking bench for ecp5pll_phase_seq
module tb_ecp5pll_phase_seq;

   localparam int S = 4;
   localparam int P = 4;
   localparam int R = 16;
   localparam int T = S + P + R;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] target;
   logic       target_valid;
   logic       target_ready;
   logic [7:0] phase;
   logic       busy;
   logic       done;
   logic       phasedir;
   logic       phasestep;
   logic       phaseloadreg;
`ifdef ECP5PLL_PHASE_SEQ_ABORT_EN
   logic       abort;
`endif

   always #5 clk = ~clk;

   ecp5pll_phase_seq dut (
      .clk          (clk),
      .rst          (rst),
      .target       (target),
      .target_valid (target_valid),
`ifdef ECP5PLL_PHASE_SEQ_ABORT_EN
      .abort        (abort),
`endif
      .target_ready (target_ready),
      .phase        (phase),
      .busy         (busy),
      .done         (done),
      .phasedir     (phasedir),
      .phasestep    (phasestep),
      .phaseloadreg (phaseloadreg)
   );

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [7:0] target;
      logic       exp_dir;
      int         exp_n;
      logic [7:0] exp_final;
      int         exp_lat;
   } vec_t;

   vec_t       vecs[9];
   logic [7:0] cur_phase;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // Issue one request starting from cur_phase and compare every cycle of the
   // response against the ideal waveform until one cycle after done.
   task automatic run_req(input logic [7:0] tgt, input logic edir, input int en,
                          input logic [7:0] efin, input int elat, input bit hold,
                          input logic [7:0] ntgt, input string tag);
      int         bad, first_bad, done_at, pulses, loads, t, steps;
      logic [7:0] sp, ephase;
      logic       estep, eload, prev_step;
      logic [13:0] exp_v, act_v;
      bit         acc;
      sp = cur_phase;
      target = tgt;
      target_valid = 1'b1;
      acc = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (target_ready) begin
            acc = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check({tag, " accept"}, int'(acc), 1);
      if (!acc) begin
         target_valid = 1'b0;
         return;
      end
      @(posedge clk);
      bad = 0; first_bad = -1; done_at = -1; pulses = 0; loads = 0;
      prev_step = 1'b1;
      for (int c = 1; c <= elat + 1; c++) begin
         @(negedge clk);
         if (c == 1) begin
            if (hold) target = ntgt;
            else target_valid = 1'b0;
         end
         t = c - 1;
         if (en == 0) begin
            estep = 1'b1; eload = 1'b0; steps = 0;
         end else if (t < T * en) begin
            estep = !((t % T) >= S && (t % T) < S + P);
            eload = 1'b0;
            steps = t / T + (((t % T) >= S + P) ? 1 : 0);
         end else begin
            estep = 1'b1;
            eload = (t - T * en) < P;
            steps = en;
         end
         ephase = edir ? sp - 8'(steps) : sp + 8'(steps);
         exp_v = {c > elat, c <= elat, c == elat, edir, estep, eload, ephase};
         act_v = {target_ready, busy, done, phasedir, phasestep, phaseloadreg, phase};
         if (act_v !== exp_v) begin
            bad++;
            if (first_bad < 0) first_bad = c;
         end
         if (done && done_at < 0) done_at = c;
         if (prev_step && !phasestep) pulses++;
         if (phaseloadreg) loads++;
         prev_step = phasestep;
      end
      if (bad != 0) $display("FAIL %s waveform: first bad cycle %0d", tag, first_bad);
      check({tag, " waveform mismatches"}, bad, 0);
      check({tag, " done latency"}, done_at, elat);
      check({tag, " step pulses"}, pulses, en);
      check({tag, " load cycles"}, loads, (en != 0) ? P : 0);
      check({tag, " final phase"}, int'(phase), int'(efin));
      check({tag, " ready after done"}, int'(target_ready), 1);
      cur_phase = efin;
   endtask

   initial begin
      int done_at, pulses;
      logic prev_step;
      bit hit;

      // target, dir, N, final phase, done latency (1 + N*24 + (N ? 4 : 0))
      vecs[0] = '{8'd3,   1'b0, 3,   8'd3,   77};
      vecs[1] = '{8'd2,   1'b1, 1,   8'd2,   29};
      vecs[2] = '{8'd254, 1'b1, 4,   8'd254, 101};
      vecs[3] = '{8'd254, 1'b0, 0,   8'd254, 1};
      vecs[4] = '{8'd0,   1'b0, 2,   8'd0,   53};
      vecs[5] = '{8'd128, 1'b1, 128, 8'd128, 3077};
      vecs[6] = '{8'd128, 1'b0, 0,   8'd128, 1};
      vecs[7] = '{8'd129, 1'b0, 1,   8'd129, 29};
      vecs[8] = '{8'd1,   1'b1, 128, 8'd1,   3077};

      rst = 1'b1;
      target = 8'd0;
      target_valid = 1'b0;
`ifdef ECP5PLL_PHASE_SEQ_ABORT_EN
      abort = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("reset phase", int'(phase), 0);
      check("reset phasestep", int'(phasestep), 1);
      check("reset phasedir", int'(phasedir), 0);
      check("reset phaseloadreg", int'(phaseloadreg), 0);
      check("reset done", int'(done), 0);
      check("reset busy", int'(busy), 0);
      check("reset target_ready", int'(target_ready), 1);
      rst = 1'b0;
      cur_phase = 8'd0;
      @(negedge clk);

      for (int i = 0; i < 9; i++)
         run_req(vecs[i].target, vecs[i].exp_dir, vecs[i].exp_n, vecs[i].exp_final,
                 vecs[i].exp_lat, 1'b0, 8'd0, $sformatf("vec%0d", i));

      // Valid held across a busy request: the changed target must wait for ready.
      run_req(8'd10, 1'b0, 9, 8'd10, 221, 1'b1, 8'd12, "hold_a");
      run_req(8'd12, 1'b0, 2, 8'd12, 53, 1'b0, 8'd0, "hold_b");

      // Reset while a decrement step pulse is low.
      target = 8'd5;
      target_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      target_valid = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (!phasestep) begin
            hit = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("rst_mid reached pulse", int'(hit), 1);
      rst = 1'b1;
      #1;
      check("rst_mid phasestep", int'(phasestep), 1);
      check("rst_mid phase", int'(phase), 0);
      check("rst_mid phasedir", int'(phasedir), 0);
      check("rst_mid busy", int'(busy), 0);
      check("rst_mid target_ready", int'(target_ready), 1);
      check("rst_mid phaseloadreg", int'(phaseloadreg), 0);
      @(negedge clk);
      rst = 1'b0;
      cur_phase = 8'd0;
      @(negedge clk);

`ifdef ECP5PLL_PHASE_SEQ_ABORT_EN
      // Abort raised in the third pulse: that step completes, then load and done.
      target = 8'd10;
      target_valid = 1'b1;
      @(posedge clk);
      done_at = -1;
      pulses = 0;
      prev_step = 1'b1;
      for (int c = 1; c <= 150; c++) begin
         @(negedge clk);
         if (c == 1) target_valid = 1'b0;
         abort = 1'b0;
         if (prev_step && !phasestep) begin
            pulses++;
            if (pulses == 3) abort = 1'b1;
         end
         prev_step = phasestep;
         if (done) begin
            done_at = c;
            break;
         end
      end
      abort = 1'b0;
      check("abort done latency", done_at, 77);
      check("abort pulses", pulses, 3);
      check("abort phase", int'(phase), 3);
      @(negedge clk);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
